// File: rtl/rhythm_pkg.sv
// Shared types and default geometry for the rhythm-game note datapath.
package rhythm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } game_state_e;

  localparam int DEF_LANES          = 3;
  localparam int DEF_SLOTS_PER_LANE = 5;
  localparam int DEF_POS_W          = 10;

  // Pattern words list lane0 in the MSB, so lane l reads bit (lanes-1-l).
  function automatic int lane_data_bit(input int lane, input int lanes);
    return lanes - 1 - lane;
  endfunction

endpackage

// File: rtl/note_lane_scheduler_if.sv
// Pattern-ROM and renderer bus of the note lane scheduler; master is the scheduler side.
interface note_lane_scheduler_if #(
  parameter int LANES          = rhythm_pkg::DEF_LANES,
  parameter int SLOTS_PER_LANE = rhythm_pkg::DEF_SLOTS_PER_LANE,
  parameter int POS_W          = rhythm_pkg::DEF_POS_W,
  parameter int IDX_W          = 5
);

  logic [IDX_W-1:0]                      note_addr;
  logic [LANES-1:0]                      note_data;
  logic [LANES*SLOTS_PER_LANE-1:0]       slot_active;
  logic [LANES*SLOTS_PER_LANE*POS_W-1:0] slot_pos;

  modport master (output note_addr, slot_active, slot_pos, input note_data);
  modport slave  (input note_addr, slot_active, slot_pos, output note_data);

endinterface

// File: rtl/lane_slot_alloc.sv
// Combinational allocator for one lane: grants the lowest-index free slot on request.
module lane_slot_alloc #(
  parameter int SLOTS = 5
) (
  input  logic [SLOTS-1:0] active,
  input  logic             request,
  output logic [SLOTS-1:0] grant,
  output logic             full
);

  // Adding one ripples through the low busy slots and lands on the first free one.
  assign grant = request ? (~active & (active + SLOTS'(1))) : '0;
  assign full  = &active;

endmodule

// File: rtl/note_lane_scheduler.sv
// Falling-note scheduler: beat-timed pattern reads, per-lane slot allocation, slot motion, game FSM.
// Build option: define SONG_LOOP_EN to wrap the song back to entry 0 instead of draining to DONE.
module note_lane_scheduler
  import rhythm_pkg::*;
#(
  parameter int LANES          = DEF_LANES,
  parameter int SLOTS_PER_LANE = DEF_SLOTS_PER_LANE,
  parameter int POS_W          = DEF_POS_W,
  parameter int BOTTOM         = 490,
  parameter int BEAT_TICKS     = 64,
  parameter int SONG_LEN       = 23,
  parameter int IDX_W          = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  note_lane_scheduler_if.master bus,
  output logic [1:0]           game_state,
  output logic                 spawn_drop
);

  localparam int NSLOT  = LANES * SLOTS_PER_LANE;
  localparam int BEAT_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [POS_W-1:0]  BOTTOM_POS = POS_W'(BOTTOM);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEAT_TICKS - 1);
  localparam logic [IDX_W-1:0]  SONG_END   = IDX_W'(SONG_LEN);

  game_state_e       state_q;
  logic [IDX_W-1:0]  addr_q;
  logic [BEAT_W-1:0] beat_q;
  logic [NSLOT-1:0]  active_q;
  logic [POS_W-1:0]  pos_q [NSLOT];

  logic                   note_fire;
  logic [LANES-1:0]       lane_req;
  logic [LANES-1:0]       lane_full;
  logic [NSLOT-1:0]       grant;
  logic [NSLOT*POS_W-1:0] pos_flat;

  assign note_fire = (beat_q == '0) && (addr_q < SONG_END);

  // Allocation sees the pre-tick active vector, so a slot retiring this tick stays unavailable.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int DBIT = lane_data_bit(l, LANES);
    assign lane_req[l] = note_fire && bus.note_data[DBIT];
    lane_slot_alloc #(.SLOTS(SLOTS_PER_LANE)) u_alloc (
      .active (active_q[l*SLOTS_PER_LANE +: SLOTS_PER_LANE]),
      .request(lane_req[l]),
      .grant  (grant[l*SLOTS_PER_LANE +: SLOTS_PER_LANE]),
      .full   (lane_full[l])
    );
  end

  always_comb begin
    pos_flat = '0;
    for (int s = 0; s < NSLOT; s++) pos_flat[s*POS_W +: POS_W] = pos_q[s];
  end

  assign bus.slot_pos    = pos_flat;
  assign bus.slot_active = active_q;
  assign bus.note_addr   = addr_q;
  assign game_state      = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      active_q   <= '0;
      spawn_drop <= 1'b0;
      for (int s = 0; s < NSLOT; s++) pos_q[s] <= '0;
    end else begin
      spawn_drop <= 1'b0;
      if (tick) begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q  <= PLAY;
              addr_q   <= '0;
              beat_q   <= '0;
              active_q <= '0;
              for (int s = 0; s < NSLOT; s++) pos_q[s] <= '0;
            end
          end
          PLAY: begin
            if (stop) begin
              state_q  <= IDLE;
              active_q <= '0;
              for (int s = 0; s < NSLOT; s++) pos_q[s] <= '0;
            end else if (!pause) begin
              for (int s = 0; s < NSLOT; s++) begin
                if (grant[s]) begin
                  active_q[s] <= 1'b1;
                  pos_q[s]    <= '0;
                end else if (active_q[s]) begin
                  if (pos_q[s] > BOTTOM_POS) begin
                    active_q[s] <= 1'b0;
                    pos_q[s]    <= '0;
                  end else begin
                    pos_q[s] <= pos_q[s] + POS_W'(1);
                  end
                end
              end
              beat_q <= (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
              if (note_fire) begin
                spawn_drop <= |(lane_req & lane_full);
`ifdef SONG_LOOP_EN
                addr_q <= (addr_q == SONG_END - IDX_W'(1)) ? '0 : addr_q + IDX_W'(1);
`else
                addr_q <= addr_q + IDX_W'(1);
`endif
              end
              if (addr_q == SONG_END && active_q == '0) state_q <= DONE;
            end
          end
          DONE: begin
            if (stop) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Self-checking bench for note_lane_scheduler: random and directed play against a slot-array model.
module tb_note_lane_scheduler;
  import rhythm_pkg::*;

  localparam int LANES      = 3;
  localparam int SPL        = 5;
  localparam int POS_W      = 10;
  localparam int BOTTOM     = 490;
  localparam int BEAT_TICKS = 4;
  localparam int SONG_LEN   = 6;
  localparam int IDX_W      = 5;
  localparam int NSLOT      = LANES * SPL;

  logic clk = 1'b0;
  logic reset, tick, start, stop, pause;
  logic [1:0] game_state;
  logic spawn_drop;
  logic [LANES-1:0] rom [0:(1<<IDX_W)-1];

  int n_cmp = 0;
  int n_fail = 0;

  int m_state, m_addr, m_beat;
  bit m_drop;
  bit m_active [NSLOT];
  int m_pos [NSLOT];
  int exp_pos0, exp_addr;

  note_lane_scheduler_if #(.LANES(LANES), .SLOTS_PER_LANE(SPL), .POS_W(POS_W), .IDX_W(IDX_W)) bus ();

  note_lane_scheduler #(
    .LANES(LANES), .SLOTS_PER_LANE(SPL), .POS_W(POS_W), .BOTTOM(BOTTOM),
    .BEAT_TICKS(BEAT_TICKS), .SONG_LEN(SONG_LEN), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .pause(pause),
    .bus(bus), .game_state(game_state), .spawn_drop(spawn_drop)
  );

  assign bus.note_data = rom[bus.note_addr];

  always #5 clk = ~clk;

  task automatic fill_rom(input bit all_ones);
    for (int i = 0; i < (1 << IDX_W); i++) rom[i] = all_ones ? '1 : LANES'($urandom);
  endtask

  task automatic clear_model_slots();
    for (int s = 0; s < NSLOT; s++) begin
      m_active[s] = 1'b0;
      m_pos[s] = 0;
    end
  endtask

  // One clock of the game rules, applied to plain slot arrays.
  task automatic model_step(input bit r, input bit tk, input bit st, input bit sp, input bit pa);
    bit prev [NSLOT];
    bit any_active, fire, done_now;
    logic [LANES-1:0] data;
    int k;
    m_drop = 1'b0;
    if (r) begin
      m_state = 0; m_addr = 0; m_beat = 0;
      clear_model_slots();
    end else if (tk) begin
      case (m_state)
        0: if (st) begin
          m_state = 1; m_addr = 0; m_beat = 0;
          clear_model_slots();
        end
        1: if (sp) begin
          m_state = 0;
          clear_model_slots();
        end else if (!pa) begin
          data = rom[m_addr];
          fire = (m_beat == 0) && (m_addr < SONG_LEN);
          any_active = 1'b0;
          for (int s = 0; s < NSLOT; s++) begin
            prev[s] = m_active[s];
            any_active |= prev[s];
          end
          done_now = (m_addr == SONG_LEN) && !any_active;
          for (int s = 0; s < NSLOT; s++) begin
            if (prev[s]) begin
              if (m_pos[s] > BOTTOM) begin
                m_active[s] = 1'b0; m_pos[s] = 0;
              end else begin
                m_pos[s] = m_pos[s] + 1;
              end
            end
          end
          if (fire) begin
            for (int l = 0; l < LANES; l++) begin
              if (data[LANES-1-l]) begin
                k = 0;
                while (k < SPL && prev[l*SPL+k]) k++;
                if (k < SPL) begin
                  m_active[l*SPL+k] = 1'b1; m_pos[l*SPL+k] = 0;
                end else begin
                  m_drop = 1'b1;
                end
              end
            end
            m_addr = m_addr + 1;
`ifdef SONG_LOOP_EN
            if (m_addr == SONG_LEN) m_addr = 0;
`endif
          end
          m_beat = (m_beat + 1) % BEAT_TICKS;
          if (done_now) m_state = 2;
        end
        2: if (sp) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic check_value(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    logic [NSLOT-1:0] exp_act;
    logic [NSLOT*POS_W-1:0] exp_pos;
    for (int s = 0; s < NSLOT; s++) begin
      exp_act[s] = m_active[s];
      exp_pos[s*POS_W +: POS_W] = POS_W'(m_pos[s]);
    end
    n_cmp++;
    assert (game_state === 2'(m_state)) else begin
      n_fail++; $error("FAIL game_state observed=%0d expected=%0d", game_state, m_state);
    end
    n_cmp++;
    assert (bus.note_addr === IDX_W'(m_addr)) else begin
      n_fail++; $error("FAIL note_addr observed=%0d expected=%0d", bus.note_addr, m_addr);
    end
    n_cmp++;
    assert (spawn_drop === m_drop) else begin
      n_fail++; $error("FAIL spawn_drop observed=%0b expected=%0b", spawn_drop, m_drop);
    end
    n_cmp++;
    assert (bus.slot_active === exp_act) else begin
      n_fail++; $error("FAIL slot_active observed=%h expected=%h", bus.slot_active, exp_act);
    end
    n_cmp++;
    assert (bus.slot_pos === exp_pos) else begin
      n_fail++; $error("FAIL slot_pos observed=%h expected=%h", bus.slot_pos, exp_pos);
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit tk, input bit st, input bit sp, input bit pa);
    reset = r; tick = tk; start = st; stop = sp; pause = pa;
    model_step(r, tk, st, sp, pa);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    fill_rom(1'b0);
    rom[0] = 3'b100;

    repeat (3) apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    check_value("reset_state", game_state, 0);
    check_value("reset_addr", bus.note_addr, 0);

    // Slow ticks: first note lands in slot0 only and starts moving.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_value("enter_play", game_state, 1);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_value("note0_act0", bus.slot_active[0], 1);
    check_value("note0_pos0", bus.slot_pos[POS_W-1:0], 0);
    check_value("note0_act5", bus.slot_active[5], 0);
    check_value("note0_act10", bus.slot_active[10], 0);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_value("note0_pos1", bus.slot_pos[POS_W-1:0], 1);

    repeat (600) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SONG_LOOP_EN
    check_value("loop_stays_play", game_state, 1);
`else
    check_value("song_done_state", game_state, 2);
    check_value("song_done_addr", bus.note_addr, SONG_LEN);
`endif
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_value("stop_to_idle", game_state, 0);

    // Every entry hits all lanes: the sixth beat finds each lane full.
    fill_rom(1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (21) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_value("drop_pulse", spawn_drop, 1);
    check_value("lanes_full", bus.slot_active, 'h7fff);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_value("drop_clears", spawn_drop, 0);
    repeat (5) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_pos0 = m_pos[0];
    exp_addr = m_addr;
    repeat (10) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_value("pause_pos0", bus.slot_pos[POS_W-1:0], exp_pos0);
    check_value("pause_addr", bus.note_addr, exp_addr);
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_value("stop_paused_state", game_state, 0);
    check_value("stop_paused_active", bus.slot_active, 0);

    // Random play, then a reset in the middle of the song.
    fill_rom(1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (60) apply_stimulus(1'b0, 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0,
                               1'($urandom_range(0, 7) == 0));
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_value("midreset_state", game_state, 0);
    check_value("midreset_addr", bus.note_addr, 0);
    check_value("midreset_active", bus.slot_active, 0);
    check_value("midreset_pos", (bus.slot_pos == '0), 1);
    check_value("midreset_drop", spawn_drop, 0);

    fill_rom(1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (1500) apply_stimulus(1'b0, 1'($urandom_range(0, 3) != 0),
                                 1'($urandom_range(0, 7) == 0),
                                 1'($urandom_range(0, 199) == 0),
                                 1'($urandom_range(0, 15) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
